bus_xbar: RTL and testbench

Parametrised shared-bus interconnect between NUM_M bus masters and NUM_S slaves: round-robin arbitration, master-to-slave request mux, address decode to active-low chip selects, and slave-to-master read-data/ready return. It replaces the fixed 4-master/8-slave bus in the top level. Unlike that bus, it never re-arbitrates while an access is outstanding, and it can optionally abort hung accesses.

---
 rtl/bus_xbar_if.sv | 35 +++
 rtl/bus_xbar.sv | 181 ++++++++++++++++++
 tb/tb_bus_xbar.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_xbar_if.sv
// Signal bundle for bus_xbar: master-side request/strobe/data and slave-side decode/return.
// Modport "slave" is the crossbar's view; modport "master" is the attached bus agents' view.
interface bus_xbar_if #(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned NUM_S  = 8,
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_M-1:0]        m_req_;
  logic [NUM_M-1:0]        m_grnt_;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M-1:0]        m_as_;
  logic [NUM_M-1:0]        m_rw;
  logic [NUM_M*DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0]       m_rd_data;
  logic                    m_rdy_;
  logic                    m_err;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_as_;
  logic                    s_rw;
  logic [DATA_W-1:0]       s_wr_data;
  logic [NUM_S-1:0]        s_cs_;
  logic [NUM_S*DATA_W-1:0] s_rd_data;
  logic [NUM_S-1:0]        s_rdy_;

  modport slave (
    input  m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
    output m_grnt_, m_rd_data, m_rdy_, m_err, s_addr, s_as_, s_rw, s_wr_data, s_cs_
  );

  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
    input  m_grnt_, m_rd_data, m_rdy_, m_err, s_addr, s_as_, s_rw, s_wr_data, s_cs_
  );
endinterface

// File: rtl/bus_xbar.sv
// Shared-bus crossbar: round-robin owner, request mux, address decode, read/ready return.
// Optional hung-access abort is enabled by defining BUS_XBAR_TIMEOUT_EN.
module bus_xbar #(
  parameter int unsigned NUM_M       = 4,
  parameter int unsigned NUM_S       = 8,
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  bus_xbar_if.slave  bus
);

  localparam int unsigned OW = $clog2(NUM_M);
  localparam int unsigned SW = $clog2(NUM_S);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state;
  logic              pend;
  logic [OW-1:0]     own;
  logic [OW-1:0]     next_own;
  logic              found;
  int unsigned       idx;

  logic [ADDR_W-1:0] own_addr;
  logic              own_as_;
  logic              own_rw;
  logic [DATA_W-1:0] own_wd;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_rw;
  logic [SW-1:0]     sel;
  logic [NUM_S-1:0]  cs_;
  logic [NUM_M-1:0]  grnt_;

  logic [DATA_W-1:0] slv_data;
  logic              slv_rdy_;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_int;
  logic              err;
  logic              to_hit;

  assign pend = (state == S_WAIT);

  always_comb begin
    own_addr = '0;
    own_as_  = 1'b1;
    own_rw   = 1'b1;
    own_wd   = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (own == OW'(i)) begin
        own_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
        own_as_  = bus.m_as_[i];
        own_rw   = bus.m_rw[i];
        own_wd   = bus.m_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_M; i++) begin
      grnt_[i] = (own != OW'(i));
    end
  end

  // Round-robin search starts just past the current owner and wraps.
  always_comb begin
    next_own = own;
    found    = 1'b0;
    idx      = 0;
    if (bus.m_req_[own]) begin
      for (int unsigned k = 1; k < NUM_M; k++) begin
        idx = own + k;
        if (idx >= NUM_M) idx = idx - NUM_M;
        if (!found && !bus.m_req_[idx]) begin
          next_own = OW'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  // While waiting, decode follows the address captured at the strobe so the
  // owner may drop or change its strobe/address after the first cycle.
  always_comb begin
    dec_addr = pend ? lat_addr : own_addr;
    dec_rw   = pend ? lat_rw   : own_rw;
    sel      = dec_addr[ADDR_W-1 -: SW];
  end

  always_comb begin
    slv_data = '0;
    slv_rdy_ = 1'b1;
    for (int unsigned i = 0; i < NUM_S; i++) begin
      cs_[i] = (sel != SW'(i));
      if (sel == SW'(i)) begin
        slv_data = bus.s_rd_data[i*DATA_W +: DATA_W];
        slv_rdy_ = bus.s_rdy_[i];
      end
    end
  end

`ifdef BUS_XBAR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] to_cnt;

  // to_cnt counts completed WAIT cycles, so the abort lands TIMEOUT_CYC cycles after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!pend) begin
      to_cnt <= '0;
    end else if (to_cnt != '1) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign to_hit = pend && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // A genuine slave ready takes priority over the timeout abort.
  always_comb begin
    rd_data = slv_data;
    rdy_int = 1'b1;
    err     = 1'b0;
    if (!own_as_ || pend) begin
      rdy_int = slv_rdy_;
    end
    if (to_hit && slv_rdy_) begin
      rdy_int = 1'b0;
      rd_data = '0;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      own      <= '0;
      lat_addr <= '0;
      lat_rw   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!own_as_) begin
            if (rdy_int) begin
              state    <= S_WAIT;
              lat_addr <= own_addr;
              lat_rw   <= own_rw;
            end
          end else begin
            own <= next_own;
          end
        end
        S_WAIT: begin
          if (!rdy_int) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_grnt_   = grnt_;
  assign bus.m_rd_data = rd_data;
  assign bus.m_rdy_    = rdy_int;
  assign bus.m_err     = err;
  assign bus.s_addr    = dec_addr;
  assign bus.s_as_     = own_as_;
  assign bus.s_rw      = dec_rw;
  assign bus.s_wr_data = own_wd;
  assign bus.s_cs_     = cs_;

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar at 4 masters / 8 slaves; timeout steps run only with BUS_XBAR_TIMEOUT_EN.
module tb_bus_xbar;

`ifdef BUS_XBAR_TIMEOUT_EN
  localparam int unsigned TB_TO = 10;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  bus_xbar_if #(.NUM_M(4), .NUM_S(8), .ADDR_W(30), .DATA_W(32)) bus ();

  bus_xbar #(
    .NUM_M(4), .NUM_S(8), .ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(TB_TO)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.m_req_  = 4'hF;
    bus.m_as_   = 4'hF;
    bus.m_rw    = 4'hF;
    bus.s_rdy_  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      bus.m_addr[i*30 +: 30]    = 30'(i) << 27;
      bus.m_wr_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    for (int i = 0; i < 8; i++) bus.s_rd_data[i*32 +: 32] = 32'hD0D0_0000 + 32'(i);

    // Reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_grnt", bus.m_grnt_, 4'b1110);
    chk("rst_cs",   bus.s_cs_,   8'b1111_1110);
    chk("rst_rdy",  bus.m_rdy_,  1'b1);
    chk("rst_err",  bus.m_err,   1'b0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Owner keeps requesting: no preemption; release hands over in one edge
    bus.m_req_[0] = 1'b0;
    bus.m_req_[1] = 1'b0;
    tick(); tick();
    chk("hold_owner", bus.m_grnt_, 4'b1110);
    bus.m_req_[0] = 1'b1;
    tick();
    chk("grant_m1", bus.m_grnt_, 4'b1101);

    // Round robin 1 -> 2 -> 3 -> 0, one zero-wait access each
    bus.m_req_ = 4'b0000;
    for (int o = 1; o < 4; o++) begin
      bus.m_as_[o]  = 1'b0;
      bus.s_rdy_[o] = 1'b0;
      #1;
      chk("rr_rdy", bus.m_rdy_, 1'b0);
      tick();
      chk("rr_hold", bus.m_grnt_, 4'hF ^ (4'b0001 << o));
      bus.m_as_[o]   = 1'b1;
      bus.s_rdy_[o]  = 1'b1;
      bus.m_req_[o]  = 1'b1;
      tick();
      chk("rr_next", bus.m_grnt_, 4'hF ^ (4'b0001 << ((o + 1) % 4)));
    end
    bus.m_req_ = 4'b1110;

    // m0 reads slave 6, ready 5 cycles after the strobe; release mid-wait ignored
    bus.m_addr[0 +: 30] = 30'h3000_0000;
    bus.m_rw[0] = 1'b1;
    bus.m_as_[0] = 1'b0;
    #1;
    chk("rd_c0_cs",  bus.s_cs_,  8'b1011_1111);
    chk("rd_c0_rdy", bus.m_rdy_, 1'b1);
    tick();
    bus.m_as_[0] = 1'b1;
    bus.m_addr[0 +: 30] = 30'h0;
    #1;
    chk("rd_c1_cs",  bus.s_cs_,  8'b1011_1111);
    chk("rd_c1_rdy", bus.m_rdy_, 1'b1);
    tick();
    bus.m_req_[0] = 1'b1;
    bus.m_req_[1] = 1'b0;
    #1;
    chk("rd_c2_grnt", bus.m_grnt_, 4'b1110);
    tick();
    chk("rd_c3_grnt", bus.m_grnt_, 4'b1110);
    chk("rd_c3_cs",   bus.s_cs_,   8'b1011_1111);
    tick();
    chk("rd_c4_rdy", bus.m_rdy_, 1'b1);
    tick();
    bus.s_rdy_[6] = 1'b0;
    #1;
    chk("rd_c5_data", bus.m_rd_data, 32'hD0D0_0006);
    chk("rd_c5_rdy",  bus.m_rdy_,    1'b0);
    chk("rd_c5_cs",   bus.s_cs_,     8'b1011_1111);
    chk("rd_c5_grnt", bus.m_grnt_,   4'b1110);
    chk("rd_c5_err",  bus.m_err,     1'b0);
    tick();
    bus.s_rdy_[6] = 1'b1;
    #1;
    chk("rd_c6_rdy", bus.m_rdy_, 1'b1);
    tick();
    chk("rd_after_grnt", bus.m_grnt_, 4'b1101);

    // Zero-wait write by m1 to slave 0: FSM stays idle, arbitration on the following edge
    bus.m_rw[1] = 1'b0;
    bus.m_addr[30 +: 30]   = 30'h0;
    bus.m_wr_data[32 +: 32] = 32'hCAFE_F00D;
    bus.m_as_[1]  = 1'b0;
    bus.s_rdy_[0] = 1'b0;
    bus.m_req_[1] = 1'b1;
    bus.m_req_[2] = 1'b0;
    #1;
    chk("zw_rw",   bus.s_rw,      1'b0);
    chk("zw_wd",   bus.s_wr_data, 32'hCAFE_F00D);
    chk("zw_cs",   bus.s_cs_,     8'b1111_1110);
    chk("zw_rdy",  bus.m_rdy_,    1'b0);
    chk("zw_data", bus.m_rd_data, 32'hD0D0_0000);
    tick();
    chk("zw_hold", bus.m_grnt_, 4'b1101);
    bus.m_as_[1]  = 1'b1;
    bus.s_rdy_[0] = 1'b1;
    #1;
    chk("zw_idle_rdy", bus.m_rdy_, 1'b1);
    tick();
    chk("zw_next", bus.m_grnt_, 4'b1011);

    // Simultaneous release and requests resolved by round-robin order, with wrap
    bus.m_req_ = 4'b0110;
    tick();
    chk("sim_m3", bus.m_grnt_, 4'b0111);
    bus.m_req_ = 4'b1100;
    tick();
    chk("wrap_m0", bus.m_grnt_, 4'b1110);

    // Nobody requesting: owner holds
    bus.m_req_ = 4'hF;
    tick(); tick();
    chk("none_hold", bus.m_grnt_, 4'b1110);

    // Reset in the middle of a wait aborts without ready or error
    bus.m_req_[1] = 1'b0;
    tick();
    chk("pre_rst_grnt", bus.m_grnt_, 4'b1101);
    bus.m_addr[30 +: 30] = 30'h3000_0000;
    bus.m_as_[1] = 1'b0;
    tick();
    bus.m_as_[1] = 1'b1;
    #1;
    chk("wait_rdy", bus.m_rdy_, 1'b1);
    #2 reset = 1'b0;
    bus.s_rdy_[6] = 1'b0;
    #1;
    chk("rst_abort_rdy",  bus.m_rdy_,  1'b1);
    chk("rst_abort_err",  bus.m_err,   1'b0);
    chk("rst_abort_grnt", bus.m_grnt_, 4'b1110);
    @(negedge clk) reset = 1'b1;
    bus.s_rdy_[6] = 1'b1;
    bus.m_req_ = 4'hF;
    tick();
    chk("post_rst_grnt", bus.m_grnt_, 4'b1110);

`ifdef BUS_XBAR_TIMEOUT_EN
    // Slave 6 never answers: abort exactly TIMEOUT_CYC cycles after the strobe
    bus.m_addr[0 +: 30] = 30'h3000_0000;
    bus.m_rw[0]   = 1'b1;
    bus.m_req_[0] = 1'b0;
    bus.m_as_[0]  = 1'b0;
    #1;
    chk("to_c0_rdy", bus.m_rdy_, 1'b1);
    tick();
    bus.m_as_[0] = 1'b1;
    for (int k = 1; k < 10; k++) begin
      #1;
      chk("to_wait_rdy", bus.m_rdy_, 1'b1);
      chk("to_wait_err", bus.m_err,  1'b0);
      tick();
    end
    bus.m_req_[0] = 1'b1;
    bus.m_req_[1] = 1'b0;
    #1;
    chk("to_rdy",  bus.m_rdy_,    1'b0);
    chk("to_err",  bus.m_err,     1'b1);
    chk("to_data", bus.m_rd_data, 32'h0);
    tick();
    chk("to_after_err", bus.m_err,  1'b0);
    chk("to_after_rdy", bus.m_rdy_, 1'b1);
    tick();
    chk("to_arb", bus.m_grnt_, 4'b1101);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
